// File: rtl/intmul_arb_pkg.sv
// Shared types and helpers for the intmul_arb multiplier-sharing block.
// Record typedefs describe the default configuration; the top derives its own widths.
package intmul_arb_pkg;

    localparam int unsigned DEF_LOGA  = 60;
    localparam int unsigned DEF_LOGB  = 60;
    localparam int unsigned DEF_N_REQ = 4;

    function automatic int unsigned id_width(input int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int unsigned default_fifo_depth(input int unsigned mul_lat);
        return mul_lat + 2;
    endfunction

    typedef logic [id_width(DEF_N_REQ)-1:0] id_t;

    typedef struct packed {
        id_t                          id;
        logic [DEF_LOGA+DEF_LOGB-1:0] c;
    } res_t;

endpackage

// File: rtl/intmul_arb_rr_arbiter.sv
// Combinational round-robin arbiter: i_ptr has top priority, then ascending indices with wrap.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_idx
);
    logic [N_REQ-1:0] w_rot;
    logic [IDW:0]     w_sum;

    assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_sum = '0;
        // Descending scan so the lowest rotated offset wins.
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (w_rot[k]) w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
        end
        if (w_sum >= (IDW+1)'(N_REQ)) w_sum = w_sum - (IDW+1)'(N_REQ);
        o_idx = w_sum[IDW-1:0];
        o_gnt = '0;
        if (|i_req) o_gnt[o_idx] = 1'b1;
    end

endmodule

// File: rtl/intmul_nonstd_BBAxBBA.sv
// Pipelined unsigned multiplier core: operand register, then LAT-1 product stages (LAT >= 2).
// Data registers carry no reset; validity is tracked by the caller.
module intmul_nonstd_BBAxBBA #(
    parameter int unsigned LOGA    = 60,
    parameter int unsigned LOGB    = 60,
    parameter int unsigned USE_CSA = 0,
    parameter int unsigned LAT     = 3
) (
    input  logic                 clk,
    input  logic [LOGA-1:0]      i_a,
    input  logic [LOGB-1:0]      i_b,
    output logic [LOGA+LOGB-1:0] o_c
);
    localparam int unsigned CW = LOGA + LOGB;

    logic [LOGA-1:0] r_a;
    logic [LOGB-1:0] r_b;
    logic [CW-1:0]   w_prod;
    logic [CW-1:0]   r_p [LAT-1];

    always_ff @(posedge clk) begin
        r_a <= i_a;
        r_b <= i_b;
    end

    generate
        if (USE_CSA != 0) begin : g_split
            // Two half-width partial products summed, mapping onto narrower DSP slices.
            localparam int unsigned HA = LOGA / 2;
            logic [CW-1:0] w_lo;
            logic [CW-1:0] w_hi;
            assign w_lo   = CW'(r_a[HA-1:0]) * CW'(r_b);
            assign w_hi   = CW'(r_a[LOGA-1:HA]) * CW'(r_b);
            assign w_prod = w_lo + (w_hi << HA);
        end else begin : g_direct
            assign w_prod = CW'(r_a) * CW'(r_b);
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_p[0] <= w_prod;
        for (int i = 1; i < int'(LAT) - 1; i++) begin
            r_p[i] <= r_p[i-1];
        end
    end

    assign o_c = r_p[LAT-2];

endmodule

// File: rtl/intmul_arb.sv
// Shares one pipelined multiplier among N_REQ requesters with credit-checked result FIFO.
// Define INTMUL_ARB_PRIO0_EN to give requester 0 fixed absolute priority.
module intmul_arb
    import intmul_arb_pkg::*;
#(
    parameter int unsigned LOGA       = 60,
    parameter int unsigned LOGB       = 60,
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MUL_LAT    = 3,
    parameter int unsigned FIFO_DEPTH = default_fifo_depth(MUL_LAT),
    parameter int unsigned USE_CSA    = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*LOGA-1:0]     req_a,
    input  logic [N_REQ*LOGB-1:0]     req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [$clog2(N_REQ)-1:0]  res_id,
    output logic [LOGA+LOGB-1:0]      res_c,
    output logic                      busy
);
    localparam int unsigned IDW = id_width(N_REQ);
    localparam int unsigned CW  = LOGA + LOGB;
    localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [OW-1:0]  DEPTH_O = OW'(FIFO_DEPTH);
    localparam logic [PW-1:0]  LAST_P  = PW'(FIFO_DEPTH - 1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [CW-1:0]  c;
    } entry_t;

    logic [N_REQ-1:0] w_arb_req, w_arb_gnt, w_gnt;
    logic [IDW-1:0]   w_arb_idx, w_gnt_idx, r_rr_ptr;
    logic             w_pop, w_credit_ok, w_issue;
    logic [OW-1:0]    r_outstanding, r_cnt;
    logic [LOGA-1:0]  w_a;
    logic [LOGB-1:0]  w_b;
    logic [CW-1:0]    w_core_c;
    logic [MUL_LAT-1:0] r_sr_vld;
    logic [IDW-1:0]   r_sr_id [MUL_LAT];
    entry_t           r_mem [FIFO_DEPTH];
    entry_t           w_in, r_res;
    logic [PW-1:0]    r_wptr, r_rptr;
    logic             w_wr, w_out_free, w_mem_pop, w_mem_push, r_res_valid;

`ifdef INTMUL_ARB_PRIO0_EN
    assign w_arb_req = req_valid & ~N_REQ'(1);
    assign w_gnt     = req_valid[0] ? N_REQ'(1) : w_arb_gnt;
    assign w_gnt_idx = req_valid[0] ? '0 : w_arb_idx;
`else
    assign w_arb_req = req_valid;
    assign w_gnt     = w_arb_gnt;
    assign w_gnt_idx = w_arb_idx;
`endif

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .i_req (w_arb_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    // The core cannot stall, so issue only when the FIFO is guaranteed a slot.
    assign w_pop       = r_res_valid & res_ready;
    assign w_credit_ok = {1'b0, r_outstanding} < ({1'b0, DEPTH_O} + {{OW{1'b0}}, w_pop});
    assign req_ready   = w_credit_ok ? w_gnt : '0;
    assign w_issue     = w_credit_ok & (|w_gnt);

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_a = req_a[i*LOGA +: LOGA];
                w_b = req_b[i*LOGB +: LOGB];
            end
        end
    end

    intmul_nonstd_BBAxBBA #(.LOGA(LOGA), .LOGB(LOGB), .USE_CSA(USE_CSA), .LAT(MUL_LAT)) u_core (
        .clk (clk),
        .i_a (w_a),
        .i_b (w_b),
        .o_c (w_core_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_outstanding <= '0;
            r_sr_vld      <= '0;
        end else begin
`ifdef INTMUL_ARB_PRIO0_EN
            if (w_issue && w_gnt_idx != '0)
                r_rr_ptr <= (w_gnt_idx == LAST_ID) ? IDW'(1) : w_gnt_idx + IDW'(1);
`else
            if (w_issue) r_rr_ptr <= (w_gnt_idx == LAST_ID) ? '0 : w_gnt_idx + IDW'(1);
`endif
            if (w_issue && !w_pop) r_outstanding <= r_outstanding + OW'(1);
            else if (!w_issue && w_pop) r_outstanding <= r_outstanding - OW'(1);
            r_sr_vld[0] <= w_issue;
            for (int i = 1; i < int'(MUL_LAT); i++) r_sr_vld[i] <= r_sr_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_sr_id[0] <= w_gnt_idx;
        for (int i = 1; i < int'(MUL_LAT); i++) r_sr_id[i] <= r_sr_id[i-1];
    end

    // Output register is filled from the FIFO head, or bypassed directly when the FIFO is empty.
    assign w_wr       = r_sr_vld[MUL_LAT-1];
    assign w_in       = '{id: r_sr_id[MUL_LAT-1], c: w_core_c};
    assign w_out_free = !r_res_valid | w_pop;
    assign w_mem_pop  = w_out_free & (r_cnt != '0);
    assign w_mem_push = w_wr & ((r_cnt != '0) | !w_out_free);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_out_free) begin
                if (r_cnt != '0) begin
                    r_res       <= r_mem[r_rptr];
                    r_res_valid <= 1'b1;
                end else if (w_wr) begin
                    r_res       <= w_in;
                    r_res_valid <= 1'b1;
                end else begin
                    r_res_valid <= 1'b0;
                end
            end
            if (w_mem_pop) r_rptr <= (r_rptr == LAST_P) ? '0 : r_rptr + PW'(1);
            if (w_mem_push) r_wptr <= (r_wptr == LAST_P) ? '0 : r_wptr + PW'(1);
            if (w_mem_push && !w_mem_pop) r_cnt <= r_cnt + OW'(1);
            else if (!w_mem_push && w_mem_pop) r_cnt <= r_cnt - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_push) r_mem[r_wptr] <= w_in;
    end

    assert property (@(posedge clk) disable iff (!rst_n) w_mem_push |-> (r_cnt < DEPTH_O))
        else $error("intmul_arb: result FIFO written while full");

    assign res_valid = r_res_valid;
    assign res_id    = r_res.id;
    assign res_c     = r_res.c;
    assign busy      = (r_outstanding != '0);

endmodule

// File: tb/tb_intmul_arb.sv
// Directed bench for intmul_arb: vector table plus contention, backpressure, reset and priority cases.
module tb_intmul_arb;
    localparam int unsigned LOGA  = 60;
    localparam int unsigned LOGB  = 60;
    localparam int unsigned N     = 4;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 5;

    typedef struct {
        logic [1:0]   id;
        logic [59:0]  a;
        logic [59:0]  b;
        logic [119:0] want;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req_valid, req_ready;
    logic [N*LOGA-1:0]  req_a;
    logic [N*LOGB-1:0]  req_b;
    logic               res_valid, res_ready, busy;
    logic [1:0]         res_id;
    logic [119:0]       res_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    intmul_arb #(
        .LOGA(LOGA), .LOGB(LOGB), .N_REQ(N), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH), .USE_CSA(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_c     (res_c),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [59:0] a, input logic [59:0] b);
        req_a[i*LOGA +: LOGA] = a;
        req_b[i*LOGB +: LOGB] = b;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        int   edges, n_iss, n_res, bubbles, n_acc, seen, n;
        logic [1:0] drain_ids[5];
        logic [1:0] eid;

        vecs[0] = '{id: 2'd2, a: 60'd3, b: 60'd5, want: 120'd15};
        vecs[1] = '{id: 2'd0, a: 60'hFFFFFFFFFFFFFFF, b: 60'hFFFFFFFFFFFFFFF,
                    want: 120'hFFFFFFFFFFFFFFE000000000000001};
        vecs[2] = '{id: 2'd1, a: 60'd12345, b: 60'd67890, want: 120'd838102050};
        vecs[3] = '{id: 2'd2, a: 60'h800000000000000, b: 60'd2, want: 120'h1000000000000000};
        vecs[4] = '{id: 2'd1, a: 60'd0, b: 60'd123, want: 120'd0};
        vecs[5] = '{id: 2'd3, a: 60'hFFFFFFFF, b: 60'h100000001, want: 120'hFFFFFFFFFFFFFFFF};
        drain_ids[0] = 2'd1; drain_ids[1] = 2'd2; drain_ids[2] = 2'd3;
        drain_ids[3] = 2'd0; drain_ids[4] = 2'd1;

        req_valid = '0;
        res_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_id", res_id, 0);
        check("reset_res_c", res_c, 0);
        check("reset_busy", busy, 0);
        #2 rst_n = 1'b1;
        next_cycle();

        // Single isolated operations: latency, id and exact product.
        for (int v = 0; v < 6; v++) begin
            set_op(int'(vecs[v].id), vecs[v].a, vecs[v].b);
            req_valid = 4'(1) << vecs[v].id;
            #1;
            check("vec_grant", req_ready, req_valid);
            next_cycle();
            req_valid = '0;
            edges = 1;
            check("vec_busy", busy, 1);
            while (!res_valid && edges < 20) begin
                next_cycle();
                edges++;
            end
            check("vec_latency", edges, LAT + 1);
            check("vec_id", res_id, vecs[v].id);
            check("vec_c", res_c, vecs[v].want);
            next_cycle();
            check("vec_idle_after", {busy, res_valid}, 0);
        end

        // Full contention: strict rotation, results in order, no bubbles.
        for (int i = 0; i < int'(N); i++) set_op(i, 60'(i + 1), 60'd10);
        req_valid = '1;
        n_iss = 0; n_res = 0; bubbles = 0;
        #1;
        for (int cyc = 0; cyc < 40 && n_res < 12; cyc++) begin
            if (req_valid != '0) begin
                check("cont_grant", req_ready, 4'(1) << (n_iss % 4));
                n_iss++;
            end
            next_cycle();
            if (res_valid) begin
                eid = 2'(n_res % 4);
                check("cont_res_id", res_id, eid);
                check("cont_res_c", res_c, 120'((n_res % 4 + 1) * 10));
                n_res++;
            end else if (n_res > 0) begin
                bubbles++;
            end
            if (n_iss == 12) req_valid = '0;
            #1;
        end
        check("cont_results", n_res, 12);
        check("cont_bubbles", bubbles, 0);
        next_cycle();
        check("cont_idle", busy, 0);

        // Backpressure: exactly DEPTH accepts, then one per popped result.
        res_ready = 1'b0;
        req_valid = '1;
        #1;
        n_acc = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (req_ready != '0) n_acc++;
            next_cycle();
            #1;
        end
        check("bp_accepts", n_acc, DEPTH);
        check("bp_blocked", req_ready, 0);
        check("bp_res_valid", res_valid, 1);
        res_ready = 1'b1;
        #1;
        check("bp_one_ready", req_ready, 4'b0010);
        check("bp_first_id", res_id, 0);
        next_cycle();
        res_ready = 1'b0;
        #1;
        check("bp_reblocked", req_ready, 0);
        req_valid = '0;
        res_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 30 && busy; cyc++) begin
            if (res_valid) begin
                if (n < 5) begin
                    check("bp_drain_id", res_id, drain_ids[n]);
                    check("bp_drain_c", res_c, 120'((int'(drain_ids[n]) + 1) * 10));
                end
                n++;
            end
            next_cycle();
        end
        check("bp_drain_count", n, 5);
        check("bp_drain_idle", busy, 0);

        // Reset with three operations in flight.
        req_valid = 4'b0110;
        #1;
        check("rst_grant0", req_ready, 4'b0100);
        next_cycle();
        #1;
        check("rst_grant1", req_ready, 4'b0010);
        next_cycle();
        #1;
        check("rst_grant2", req_ready, 4'b0100);
        next_cycle();
        req_valid = '0;
        check("rst_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        #8 rst_n = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            next_cycle();
            if (res_valid || busy) seen++;
        end
        check("rst_no_result", seen, 0);
        req_valid = '1;
        #1;
        check("rst_ptr_zero", req_ready, 4'b0001);
        next_cycle();
        req_valid = '0;
        for (int cyc = 0; cyc < 20 && busy; cyc++) next_cycle();
        check("rst_after_idle", busy, 0);

        // Requesters 0 and 1 contending.
        req_valid = 4'b0011;
        #1;
        for (int k = 0; k < 6; k++) begin
`ifdef INTMUL_ARB_PRIO0_EN
            check("prio_grant", req_ready, 4'b0001);
`else
            check("pair_grant", req_ready, (k % 2 == 0) ? 4'b0010 : 4'b0001);
`endif
            next_cycle();
            #1;
        end
        req_valid = 4'b0010;
        #1;
        check("pair_req1_after_drop", req_ready, 4'b0010);
        next_cycle();
        req_valid = '0;
        for (int cyc = 0; cyc < 20 && busy; cyc++) next_cycle();
        check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
